// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
// The FSM state and grant encodings are visible here for debug and test benches.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Request/ack handshakes for the write and read requesters plus the APB bus.
// Handshake: a requester holds req high with stable payload until its one-cycle ack; err/rd_data are valid only with ack.
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wr_req;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [2:0]              wr_prot;
    logic                    wr_ack;
    logic                    wr_err;

    logic                    rd_req;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [2:0]              rd_prot;
    logic                    rd_ack;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;

    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    psel;
    logic                    penable;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        input  wr_req, wr_addr, wr_data, wr_strb, wr_prot,
        output wr_ack, wr_err,
        input  rd_req, rd_addr, rd_prot,
        output rd_ack, rd_data, rd_err,
        output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        input  pready, prdata, pslverr
    );

    modport slave (
        output wr_req, wr_addr, wr_data, wr_strb, wr_prot,
        input  wr_ack, wr_err,
        output rd_req, rd_addr, rd_prot,
        input  rd_ack, rd_data, rd_err,
        input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the write and read requesters.
// The last-grant register only moves when the caller signals an accepted grant.
module rr_arb2
    import apb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_wr_i,
    input  logic req_rd_i,
    input  logic upd_i,
    output gnt_e gnt_o
);

    gnt_e last_q, last_d;

    // On contention the side that did not win last time gets the grant.
    always_comb begin
        gnt_o = GNT_WR;
        if (req_wr_i && req_rd_i) begin
            gnt_o = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (req_rd_i) begin
            gnt_o = GNT_RD;
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && (req_wr_i || req_rd_i)) begin
            last_d = gnt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB requester that arbitrates between a write port and a read port,
// running one IDLE/SETUP/ACCESS transfer at a time with an ACCESS timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_master_arbiter_if.master   bus,
    output state_e                 dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    gnt_e                    gnt_q, gnt_d;
    gnt_e                    arb_gnt;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;

    logic any_req;
    logic done_ok;
    logic done_to;
    logic done;
    logic xfer_err;

    assign any_req = bus.wr_req || bus.rd_req;
    assign done_ok = (state_q == ACCESS) && bus.pready;
    assign done_to = (state_q == ACCESS) && !bus.pready && (cnt_q == CNT_W'(TIMEOUT));
    assign done    = done_ok || done_to;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_wr_i (bus.wr_req),
        .req_rd_i (bus.rd_req),
        .upd_i    (state_q == IDLE),
        .gnt_o    (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_WR;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    // The counter holds the 1-based index of the current ACCESS cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(1);
            end
            ACCESS: begin
                if (done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d     = arb_gnt;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    if (arb_gnt == GNT_WR) begin
                        paddr_d  = bus.wr_addr;
                        pprot_d  = bus.wr_prot;
                        pwrite_d = 1'b1;
                        pwdata_d = bus.wr_data;
                        pstrb_d  = bus.wr_strb;
                    end else begin
                        // Reads leave pwdata as-is to avoid needless bus toggling.
                        paddr_d  = bus.rd_addr;
                        pprot_d  = bus.rd_prot;
                        pwrite_d = 1'b0;
                        pstrb_d  = '0;
                    end
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                if (done) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // Acks are combinational on the completing ACCESS cycle; reset suppresses them.
    always_comb begin
        xfer_err    = done_to || bus.pslverr;
        bus.wr_ack  = done && (gnt_q == GNT_WR) && !rst;
        bus.rd_ack  = done && (gnt_q == GNT_RD) && !rst;
        bus.wr_err  = bus.wr_ack && xfer_err;
        bus.rd_err  = bus.rd_ack && xfer_err;
        bus.rd_data = (bus.rd_ack && done_ok) ? bus.prdata : '0;
    end

    assign bus.paddr   = paddr_q;
    assign bus.pprot   = pprot_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pstrb   = pstrb_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized bench for apb_master_arbiter against a transaction-level model.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Transaction-level model: who won last, and what pwdata the bus is holding.
    bit            m_last_rd;
    logic [DW-1:0] m_pwdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_wr();
        bus.wr_addr = $urandom;
        bus.wr_data = $urandom;
        bus.wr_strb = 4'($urandom_range(0, 15));
        bus.wr_prot = 3'($urandom_range(0, 7));
    endtask

    task automatic rand_rd();
        bus.rd_addr = $urandom;
        bus.rd_prot = 3'($urandom_range(0, 7));
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests already driven.
    // waits >= TO means pready never rises and the timeout must fire.
    task automatic transfer(input int waits, input bit slverr, output bit won_rd);
        logic [AW-1:0]   e_addr;
        logic [2:0]      e_prot;
        logic            e_write;
        logic [DW-1:0]   e_wdata;
        logic [DW/8-1:0] e_strb;
        logic [DW-1:0]   pd;
        bit              timed_out;
        int              n_access;

        if (bus.wr_req && bus.rd_req) won_rd = !m_last_rd;
        else                          won_rd = bus.rd_req;
        m_last_rd = won_rd;
        if (!won_rd) begin
            e_addr = bus.wr_addr; e_prot = bus.wr_prot; e_write = 1'b1;
            e_wdata = bus.wr_data; e_strb = bus.wr_strb;
            m_pwdata = bus.wr_data;
        end else begin
            e_addr = bus.rd_addr; e_prot = bus.rd_prot; e_write = 1'b0;
            e_wdata = m_pwdata; e_strb = '0;
        end

        @(posedge clk); #1;
        chk("setup_psel", bus.psel, 1);
        chk("setup_penable", bus.penable, 0);
        chk("setup_paddr", bus.paddr, e_addr);
        chk("setup_pprot", bus.pprot, e_prot);
        chk("setup_pwrite", bus.pwrite, e_write);
        chk("setup_pwdata", bus.pwdata, e_wdata);
        chk("setup_pstrb", bus.pstrb, e_strb);
        chk("setup_ack", {bus.wr_ack, bus.rd_ack}, 0);

        @(posedge clk); #1;
        chk("access_penable", bus.penable, 1);
        timed_out = (waits >= TO);
        n_access  = timed_out ? TO : waits + 1;
        for (int c = 1; c <= n_access; c++) begin
            pd = $urandom;
            bus.prdata  = pd;
            bus.pready  = !timed_out && (c == n_access);
            bus.pslverr = (c == n_access) ? slverr : 1'($urandom_range(0, 1));
            #1;
            chk("access_psel", bus.psel, 1);
            chk("access_paddr", bus.paddr, e_addr);
            chk("access_state", dbg_state, ACCESS);
            if (c < n_access) begin
                chk("early_ack", {bus.wr_ack, bus.rd_ack}, 0);
            end else begin
                chk("wr_ack", bus.wr_ack, !won_rd);
                chk("rd_ack", bus.rd_ack, won_rd);
                if (won_rd) begin
                    chk("rd_err", bus.rd_err, timed_out || slverr);
                    chk("rd_data", bus.rd_data, timed_out ? '0 : pd);
                end else begin
                    chk("wr_err", bus.wr_err, timed_out || slverr);
                end
            end
            @(posedge clk); #1;
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk("idle_psel", bus.psel, 0);
        chk("idle_penable", bus.penable, 0);
        chk("idle_ack", {bus.wr_ack, bus.rd_ack}, 0);
        chk("idle_state", dbg_state, IDLE);
    endtask

    task automatic reset_model();
        m_last_rd = 1'b1;
        m_pwdata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        bus.wr_req = 0; bus.rd_req = 0; bus.pready = 0; bus.pslverr = 0; bus.prdata = '0;
        rand_wr(); rand_rd();
        reset_model();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pstrb", bus.pstrb, 0);
        chk("rst_pprot", bus.pprot, 0);
        chk("rst_acks", {bus.wr_ack, bus.rd_ack, bus.wr_err, bus.rd_err}, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 0;
        @(posedge clk); #1;

        // Simple write, zero wait states.
        bus.wr_req = 1; bus.wr_addr = 32'h10; bus.wr_data = 32'hA5A5A5A5;
        bus.wr_strb = 4'hF; bus.wr_prot = 3'd0;
        transfer(0, 0, w);
        chk("w1_winner", w, 0);
        bus.wr_req = 0;

        // Read with three wait states; pwdata must keep the earlier write data.
        bus.rd_req = 1; bus.rd_addr = 32'h20; bus.rd_prot = 3'd2;
        transfer(3, 0, w);
        chk("r1_winner", w, 1);
        bus.rd_req = 0;

        // Read that never sees pready: timeout after TO ACCESS cycles.
        bus.rd_req = 1; rand_rd();
        transfer(TO, 0, w);
        bus.rd_req = 0;

        // Write answered with pslverr.
        bus.wr_req = 1; rand_wr();
        transfer(1, 1, w);
        bus.wr_req = 0;

        // Reset in the middle of a read: no ack, bus drops at the next edge.
        bus.rd_req = 1; rand_rd();
        @(posedge clk); #1;
        chk("mid_setup_psel", bus.psel, 1);
        @(posedge clk); #1;
        chk("mid_access_penable", bus.penable, 1);
        @(posedge clk); #1;
        bus.pready = 1; rst = 1;
        #1;
        chk("mid_rst_no_ack", {bus.wr_ack, bus.rd_ack}, 0);
        @(posedge clk); #1;
        chk("mid_rst_psel", bus.psel, 0);
        chk("mid_rst_penable", bus.penable, 0);
        chk("mid_rst_ack", {bus.wr_ack, bus.rd_ack}, 0);
        rst = 0; bus.pready = 0; bus.rd_req = 0;
        reset_model();
        @(posedge clk); #1;
        chk("post_rst_state", dbg_state, IDLE);

        // Both requesters held: grants must alternate W,R,W,R starting with write.
        bus.wr_req = 1; bus.rd_req = 1; rand_wr(); rand_rd();
        transfer(0, 0, w); chk("rr_0", w, 0);
        transfer(1, 0, w); chk("rr_1", w, 1);
        transfer(0, 0, w); chk("rr_2", w, 0);
        transfer(2, 0, w); chk("rr_3", w, 1);
        bus.wr_req = 0; bus.rd_req = 0;

        // Randomized mix of requests, wait states, errors and timeouts.
        for (int i = 0; i < 40; i++) begin
            int wt;
            if (!bus.wr_req && $urandom_range(0, 1) == 1) begin bus.wr_req = 1; rand_wr(); end
            if (!bus.rd_req && $urandom_range(0, 1) == 1) begin bus.rd_req = 1; rand_rd(); end
            if (!bus.wr_req && !bus.rd_req) begin
                if ($urandom_range(0, 1) == 1) begin bus.wr_req = 1; rand_wr(); end
                else begin bus.rd_req = 1; rand_rd(); end
            end
            wt = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
            transfer(wt, 1'($urandom_range(0, 3) == 0), w);
            if (!w) begin
                if ($urandom_range(0, 1) == 1) rand_wr(); else bus.wr_req = 0;
            end else begin
                if ($urandom_range(0, 1) == 1) rand_rd(); else bus.rd_req = 0;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
